// File: rtl/instr_fetch.sv
// Instruction fetch unit: pipelined imem requests, in-order response buffer, redirect flush.
// Optional IFU_MISALIGN_CHECK_EN traps misaligned redirect targets in a sticky FAULT state.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SumW = CntW + 1;
    localparam logic [SumW-1:0] DepthW = SumW'(DEPTH);
    localparam logic [31:0] ResetPcA = {RESET_PC[31:2], 2'b00};

    typedef enum logic [0:0] {StFetch, StFault} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0]   outst_q, outst_d;
    logic [CntW-1:0]   discard_q, discard_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]       buf_inst_q [DEPTH];
    logic [31:0]       buf_pc_q [DEPTH];

    logic [31:0]       target;
    logic [SumW-1:0]   used;
    logic [SumW-1:0]   inflight;
    logic              grant, rsp_fire, accept, drop, push, pop;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned  = |redirect_pc[1:0];
    assign fetch_fault = (state_q == StFault);
`else
    logic unused_lsb;
    assign unused_lsb  = ^redirect_pc[1:0];
    assign fetch_fault = 1'b0;
`endif

    assign target     = {redirect_pc[31:2], 2'b00};
    assign imem_addr  = pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = buf_inst_q[rd_ptr_q];
    assign inst_pc    = buf_pc_q[rd_ptr_q];

    // A head popped this cycle frees its slot, so back-to-back fetch keeps a full stream.
    assign used     = {1'b0, outst_q} + {1'b0, count_q} - SumW'(pop);
    assign inflight = {1'b0, discard_q} + {1'b0, outst_q};
    assign imem_req = reset && (state_q == StFetch) && !redirect &&
                      (used < DepthW) && (inflight < DepthW);

    assign grant    = imem_req && imem_gnt;
    // Responses with nothing in flight (e.g. straight after reset) are ignored outright.
    assign rsp_fire = imem_rvalid && ((outst_q != '0) || (discard_q != '0));
    assign drop     = rsp_fire && (discard_q != '0);
    assign accept   = rsp_fire && (discard_q == '0);
    assign push     = accept && !redirect;
    assign pop      = inst_valid && inst_ready && !redirect;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (redirect) begin
            pc_d      = target;
            rsp_pc_d  = target;
            outst_d   = '0;
            discard_d = discard_q + outst_q - CntW'(rsp_fire);
            count_d   = '0;
            rd_ptr_d  = wr_ptr_q;
`ifdef IFU_MISALIGN_CHECK_EN
            state_d   = misaligned ? StFault : StFetch;
`endif
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            outst_d = outst_q + CntW'(grant) - CntW'(accept);
            if (drop) begin
                discard_d = discard_q - CntW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= ResetPcA;
            rsp_pc_q  <= ResetPcA;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_inst_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else if (push) begin
            buf_inst_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model with controllable grant/response timing,
// expected instructions queued at grant time and compared whenever the decoder pops.
module tb_instr_fetch;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    int          grant_cnt = 0;
    bit          rsp_en = 1'b1;
    bit          force_rv = 1'b0;
    logic [31:0] pend_q [$];
    exp_t        exp_q [$];

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the response, settle, score pops/grants, advance past the edge.
    task automatic step();
        exp_t e;
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (rsp_en && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        if (!reset) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            if (inst_valid && inst_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    chkb("sb_unexpected_inst", inst_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst_pc", inst_pc, e.pc);
                    chk("sb_inst", inst, e.data);
                end
            end
            if (redirect) exp_q.delete();
            if (imem_req && imem_gnt) begin
                grant_cnt++;
                pend_q.push_back(imem_addr);
                e.pc   = imem_addr;
                e.data = mem_word(imem_addr);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

        // Reset state
        step(); step();
        #1;
        chkb("rst_imem_req", imem_req, 1'b0);
        chkb("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chkb("rst_fetch_fault", fetch_fault, 1'b0);

        // Release: first fetch at RESET_PC, then a gap-free stream 0,4,8 from cycle 3
        reset = 1'b1;
        #1;
        chkb("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        step(); #1;
        chk("second_addr", imem_addr, 32'h4);
        step(); #1;
        chkb("c3_valid", inst_valid, 1'b1);
        chk("c3_inst_pc", inst_pc, 32'h0);
        step(); #1;
        chk("c4_inst_pc", inst_pc, 32'h4);
        step(); #1;
        chk("c5_inst_pc", inst_pc, 32'h8);
        repeat (3) step();

        // Two responses held back, then redirect to 0x100
        rsp_en = 1'b0;
        repeat (3) step();
        #1;
        chkb("credit_full_req", imem_req, 1'b0);
        rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chkb("redirect_req_low", imem_req, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        chkb("post_redir_req", imem_req, 1'b1);
        chk("post_redir_addr", imem_addr, 32'h100);
        chkb("post_redir_valid", inst_valid, 1'b0);
        step(); step(); #1;
        chkb("redir_head_valid", inst_valid, 1'b1);
        chk("redir_head_pc", inst_pc, 32'h100);
        repeat (3) step();

        // Wrap of the fetch pc
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        chkb("wrap_req", imem_req, 1'b1);
        step(); #1;
        chk("wrap_addr1", imem_addr, 32'h0);
        step(); #1;
        chk("wrap_inst_pc0", inst_pc, 32'hFFFF_FFFC);
        step(); #1;
        chk("wrap_inst_pc1", inst_pc, 32'h0);

        // Grant withheld while the request for 0x8 is pending
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        step(); step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("gnt_stall_addr", imem_addr, 32'h8);
            chkb("gnt_stall_req", imem_req, 1'b1);
            step();
        end
        imem_gnt = 1'b1;
        #1;
        chk("gnt_resume_addr", imem_addr, 32'h8);
        step(); #1;
        chk("gnt_next_addr", imem_addr, 32'hC);
        repeat (3) step();

        // Mid-run reset with spurious responses around release; decoder stalled 10 cycles
        reset = 1'b0; inst_ready = 1'b0;
        step();
        force_rv = 1'b1;
        step();
        reset = 1'b1; grant_cnt = 0;
        #1;
        chkb("rerst_req", imem_req, 1'b1);
        chk("rerst_addr", imem_addr, 32'h0);
        step();
        force_rv = 1'b0;
        repeat (9) step();
        #1;
        chk("stall_grants", grant_cnt, 32'd2);
        chkb("stall_req_low", imem_req, 1'b0);
        chkb("stall_valid", inst_valid, 1'b1);
        chk("stall_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (4) step();

`ifdef IFU_MISALIGN_CHECK_EN
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        #1;
        chkb("mis_fault", fetch_fault, 1'b1);
        chkb("mis_req", imem_req, 1'b0);
        chkb("mis_valid", inst_valid, 1'b0);
        repeat (3) step();
        #1;
        chkb("mis_fault_sticky", fetch_fault, 1'b1);
        chkb("mis_req_still_low", imem_req, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        #1;
        chkb("recover_fault", fetch_fault, 1'b0);
        chkb("recover_req", imem_req, 1'b1);
        chk("recover_addr", imem_addr, 32'h200);
        repeat (3) step();
`else
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        #1;
        chk("mask_addr", imem_addr, 32'h100);
        chkb("mask_req", imem_req, 1'b1);
        chkb("mask_fault", fetch_fault, 1'b0);
        repeat (3) step();
`endif

        // Drain everything still expected
        imem_gnt = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("drain_empty", exp_q.size(), 32'd0);
        #1;
        chkb("drain_valid", inst_valid, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
